// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared definitions for the data-memory arbiter: default data/address
//   width, access-size and command encodings (common with the LSU), the
//   owner encoding used to steer responses, and the routing-FIFO entry type.
package dmem_arbiter_pkg;

  localparam int DMEM_XLEN = 32;

  // Access size encoding on *_width
  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  // Command encoding on *_cmd
  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Which master issued an outstanding request
  localparam logic OWNER_LSU = 1'b0;
  localparam logic OWNER_AUX = 1'b1;

  // One in-order routing record per outstanding request
  typedef struct packed {
    logic owner;
    logic drop;
  } route_t;

endpackage

// File: rtl/dmem_route_fifo.sv
// dmem_route_fifo
//   In-order record of outstanding dmem requests. Each entry remembers the
//   issuing master and whether its response must be swallowed.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   push_i/push_owner_i append a record for a request granted this cycle
//   pop_i               retire the head (response arriving this cycle)
//   drop_lsu_i          mark every LSU-owned record as drop
//   empty_o, full_o     occupancy flags
//   head_owner_o/head_drop_o  routing info of the oldest record
// The caller never pushes when full without popping, nor pops when empty.
module dmem_route_fifo
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic push_owner_i,
  input  logic pop_i,
  input  logic drop_lsu_i,
  output logic empty_o,
  output logic full_o,
  output logic head_owner_o,
  output logic head_drop_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  route_t [DEPTH-1:0] ent_q, ent_d;

  always_comb begin
    ent_d = ent_q;
    // Marking stale (already retired) LSU slots is harmless: a push rewrites
    // both fields, so no per-slot valid tracking is needed here.
    if (drop_lsu_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].owner == OWNER_LSU) ent_d[i].drop = 1'b1;
      end
    end
    if (push_i) begin
      ent_d[wr_ptr_q].owner = push_owner_i;
      ent_d[wr_ptr_q].drop  = drop_lsu_i & (push_owner_i == OWNER_LSU);
    end

    // Power-of-two depth: pointers wrap naturally
    wr_ptr_d = push_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload needs no reset: count gates its visibility
  always_ff @(posedge clk_i) begin
    ent_q <= ent_d;
  end

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CW'(DEPTH));
  assign head_owner_o = ent_q[rd_ptr_q].owner;
  assign head_drop_o  = ent_q[rd_ptr_q].drop;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one data-memory port between the LSU (m0) and an auxiliary
//   requester such as debug/DMA (m1). One round-robin grant per cycle,
//   up to DEPTH outstanding requests, responses steered back in order.
//   clear_pipeline blocks m0 and discards its outstanding responses.
// Ports:
//   clk, rst (async, active-low)
//   m0_*/m1_*   master request inputs, grant and response outputs
//   dmem_*      downstream request outputs, grant/response inputs
//   clear_pipeline  LSU flush
//   unexp_resp  sticky flag: response seen with nothing outstanding
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int XLEN  = DMEM_XLEN,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_cmd,
  input  logic [1:0]      m0_width,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_wdata,
  output logic            m0_gnt,
  output logic [XLEN-1:0] m0_rdata,
  output logic            m0_resp,
  output logic            m0_err,
  input  logic            m1_req,
  input  logic            m1_cmd,
  input  logic [1:0]      m1_width,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_wdata,
  output logic            m1_gnt,
  output logic [XLEN-1:0] m1_rdata,
  output logic            m1_resp,
  output logic            m1_err,
  output logic            dmem_req,
  output logic            dmem_cmd,
  output logic [1:0]      dmem_width,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_resp,
  input  logic            dmem_err,
  input  logic            clear_pipeline,
  output logic            unexp_resp
);

  logic last_q, last_d;
  logic unexp_q, unexp_d;
  logic elig0, elig1, winner, space, push, pop, fwd;
  logic fifo_empty, fifo_full, head_owner, head_drop;

  dmem_route_fifo #(.DEPTH(DEPTH)) u_route_fifo (
    .clk_i        (clk),
    .rst_ni       (rst),
    .push_i       (push),
    .push_owner_i (winner),
    .pop_i        (pop),
    .drop_lsu_i   (clear_pipeline),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full),
    .head_owner_o (head_owner),
    .head_drop_o  (head_drop)
  );

  always_comb begin
    elig0  = m0_req & ~clear_pipeline;
    elig1  = m1_req;
    // Contended: the master not granted last time wins. last_q holds the
    // owner code of the last grant, so its inverse names the winner.
    winner = (elig0 & elig1) ? ~last_q : elig1;
    // A full FIFO still has room if its head retires this cycle
    space  = ~fifo_full | dmem_resp;
    // rst gating keeps all outputs low while reset is held
    dmem_req = rst & (elig0 | elig1) & space;
    push     = dmem_req & dmem_gnt;
    m0_gnt   = push & (winner == OWNER_LSU);
    m1_gnt   = push & (winner == OWNER_AUX);

    dmem_cmd   = 1'b0;
    dmem_width = '0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    if (dmem_req) begin
      dmem_cmd   = winner ? m1_cmd   : m0_cmd;
      dmem_width = winner ? m1_width : m0_width;
      dmem_addr  = winner ? m1_addr  : m0_addr;
      dmem_wdata = winner ? m1_wdata : m0_wdata;
    end

    pop = dmem_resp & ~fifo_empty;
    // A head popped during a flush still carries its pre-flush drop bit
    fwd = pop & ~head_drop;
    m0_resp  = fwd & (head_owner == OWNER_LSU);
    m1_resp  = fwd & (head_owner == OWNER_AUX);
    m0_rdata = m0_resp ? dmem_rdata : '0;
    m1_rdata = m1_resp ? dmem_rdata : '0;
    m0_err   = m0_resp & dmem_err;
    m1_err   = m1_resp & dmem_err;

    last_d  = push ? winner : last_q;
    unexp_d = unexp_q | (dmem_resp & fifo_empty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q  <= OWNER_AUX;
      unexp_q <= 1'b0;
    end else begin
      last_q  <= last_d;
      unexp_q <= unexp_d;
    end
  end

  assign unexp_resp = unexp_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            m0_req, m0_cmd, m1_req, m1_cmd;
  logic [1:0]      m0_width, m1_width;
  logic [XLEN-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic            m0_gnt, m0_resp, m0_err, m1_gnt, m1_resp, m1_err;
  logic [XLEN-1:0] m0_rdata, m1_rdata;
  logic            dmem_req, dmem_cmd, dmem_gnt, dmem_resp, dmem_err;
  logic [1:0]      dmem_width;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic            clear_pipeline, unexp_resp;

  dmem_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_width(m0_width), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_resp(m0_resp),
    .m0_err(m0_err),
    .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_width(m1_width), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_resp(m1_resp),
    .m1_err(m1_err),
    .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .dmem_err(dmem_err),
    .clear_pipeline(clear_pipeline), .unexp_resp(unexp_resp)
  );

  // Reference model: queue of outstanding requests in issue order
  typedef struct {
    bit owner;
    bit drop;
  } ent_t;
  ent_t mq[$];
  bit   mlast;
  bit   munexp;
  bit   s_win, s_push, s_pop;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_cmd = 0; m0_width = 2'd2; m0_addr = 32'h100; m0_wdata = 0;
    m1_req = 0; m1_cmd = 1; m1_width = 2'd2; m1_addr = 32'h200; m1_wdata = 32'hCAFE0000;
    dmem_gnt = 0; dmem_rdata = 0; dmem_resp = 0; dmem_err = 0; clear_pipeline = 0;
  endtask

  // Compare all outputs against the model, mid-cycle
  task automatic sample_check();
    bit e0, e1, win, ereq, pop, fwd, r0, r1;
    ent_t h;
    #4;
    if (!rst) begin
      mq.delete(); mlast = 1; munexp = 0;
    end
    e0   = m0_req && !clear_pipeline;
    e1   = m1_req;
    win  = (e0 && e1) ? (mlast == 0) : e1;
    ereq = rst && (e0 || e1) && ((mq.size() < DEPTH) || dmem_resp);
    pop  = rst && dmem_resp && (mq.size() > 0);
    fwd  = 0;
    h    = '{owner: 0, drop: 0};
    if (pop) begin
      h   = mq[0];
      fwd = !h.drop;
    end
    r0 = fwd && !h.owner;
    r1 = fwd && h.owner;
    chk("dmem_req", dmem_req, ereq);
    chk("m0_gnt", m0_gnt, ereq && dmem_gnt && !win);
    chk("m1_gnt", m1_gnt, ereq && dmem_gnt && win);
    chk("dmem_cmd", dmem_cmd, !ereq ? 0 : (win ? m1_cmd : m0_cmd));
    chk("dmem_width", dmem_width, !ereq ? 0 : (win ? m1_width : m0_width));
    chk("dmem_addr", dmem_addr, !ereq ? 0 : (win ? m1_addr : m0_addr));
    chk("dmem_wdata", dmem_wdata, !ereq ? 0 : (win ? m1_wdata : m0_wdata));
    chk("m0_resp", m0_resp, r0);
    chk("m0_rdata", m0_rdata, r0 ? dmem_rdata : 0);
    chk("m0_err", m0_err, r0 && dmem_err);
    chk("m1_resp", m1_resp, r1);
    chk("m1_rdata", m1_rdata, r1 ? dmem_rdata : 0);
    chk("m1_err", m1_err, r1 && dmem_err);
    chk("unexp_resp", unexp_resp, munexp);
    s_win  = win;
    s_push = ereq && dmem_gnt;
    s_pop  = pop;
  endtask

  // Clock edge, then update the model exactly as the rules describe
  task automatic advance();
    @(posedge clk);
    if (!rst) begin
      mq.delete(); mlast = 1; munexp = 0;
    end else begin
      if (dmem_resp && mq.size() == 0) munexp = 1;
      if (s_pop) void'(mq.pop_front());
      if (clear_pipeline) foreach (mq[i]) if (mq[i].owner == 0) mq[i].drop = 1;
      if (s_push) begin
        mq.push_back('{owner: s_win, drop: 0});
        mlast = s_win;
      end
    end
    #1;
  endtask

  task automatic step();
    sample_check();
    advance();
  endtask

  typedef struct {
    bit m0r, m1r, g, rsp, err;
    logic [31:0] rdata;
    bit x_g0, x_g1, x_req, x_r0, x_r1, x_e1;
    logic [31:0] x_d0, x_d1;
  } vec_t;
  vec_t tbl[8];

  int n0, n1;

  initial begin
    // m0r m1r g rsp err rdata | g0 g1 req r0 r1 e1 d0 d1
    tbl[0] = '{1, 0, 1, 0, 0, 32'h0,        1, 0, 1, 0, 0, 0, 32'h0, 32'h0};
    tbl[1] = '{0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0, 32'h0};
    tbl[2] = '{0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 32'hDEADBEEF, 32'h0};
    tbl[3] = '{1, 1, 1, 0, 0, 32'h0,        0, 1, 1, 0, 0, 0, 32'h0, 32'h0};
    tbl[4] = '{1, 1, 1, 0, 0, 32'h0,        1, 0, 1, 0, 0, 0, 32'h0, 32'h0};
    tbl[5] = '{1, 1, 1, 1, 0, 32'h11,       0, 1, 1, 0, 1, 0, 32'h0, 32'h11};
    tbl[6] = '{0, 0, 0, 1, 0, 32'h22,       0, 0, 0, 1, 0, 0, 32'h22, 32'h0};
    tbl[7] = '{0, 0, 0, 1, 1, 32'h33,       0, 0, 0, 0, 1, 1, 32'h0, 32'h33};

    mq.delete(); mlast = 1; munexp = 0;
    idle_inputs();
    rst = 0;
    m1_req = 1; dmem_gnt = 1;           // outputs must stay low under reset
    @(posedge clk); #1;
    step();
    rst = 1;
    idle_inputs();

    // Table-driven: single read, contention, error routing
    for (int i = 0; i < 8; i++) begin
      m0_req = tbl[i].m0r; m1_req = tbl[i].m1r; dmem_gnt = tbl[i].g;
      dmem_resp = tbl[i].rsp; dmem_err = tbl[i].err; dmem_rdata = tbl[i].rdata;
      sample_check();
      chk($sformatf("tbl%0d_g0", i), m0_gnt, tbl[i].x_g0);
      chk($sformatf("tbl%0d_g1", i), m1_gnt, tbl[i].x_g1);
      chk($sformatf("tbl%0d_req", i), dmem_req, tbl[i].x_req);
      chk($sformatf("tbl%0d_r0", i), m0_resp, tbl[i].x_r0);
      chk($sformatf("tbl%0d_r1", i), m1_resp, tbl[i].x_r1);
      chk($sformatf("tbl%0d_e1", i), m1_err, tbl[i].x_e1);
      chk($sformatf("tbl%0d_d0", i), m0_rdata, tbl[i].x_d0);
      chk($sformatf("tbl%0d_d1", i), m1_rdata, tbl[i].x_d1);
      advance();
    end
    idle_inputs();

    // Backpressure: fill, blocked fifth request, pop frees a slot same cycle
    rst = 0; step(); rst = 1;
    m0_req = 1; dmem_gnt = 1;
    for (int i = 0; i < DEPTH; i++) step();
    sample_check();
    chk("full_blocks_req", dmem_req, 0);
    advance();
    dmem_resp = 1; dmem_rdata = 32'h55;
    sample_check();
    chk("full_pop_req", dmem_req, 1);
    chk("full_pop_gnt", m0_gnt, 1);
    chk("full_pop_resp", m0_resp, 1);
    advance();
    m0_req = 0;
    for (int i = 0; i < DEPTH; i++) begin
      dmem_rdata = 32'h60 + i;
      step();
    end
    idle_inputs();

    // Flush: m0, m1, m0 outstanding, then clear_pipeline
    dmem_gnt = 1;
    m0_req = 1; step();
    m0_req = 0; m1_req = 1; step();
    m1_req = 0; m0_req = 1; step();
    clear_pipeline = 1;
    sample_check();
    chk("flush_m0_gnt", m0_gnt, 0);
    chk("flush_req", dmem_req, 0);
    advance();
    idle_inputs();
    n0 = 0; n1 = 0;
    for (int i = 0; i < 3; i++) begin
      dmem_resp = 1; dmem_rdata = 32'hA0 + i;
      sample_check();
      n0 += int'(m0_resp); n1 += int'(m1_resp);
      advance();
    end
    chk("flush_m0_pulses", n0, 0);
    chk("flush_m1_pulses", n1, 1);
    idle_inputs();

    // Unexpected response, sticky flag, then async reset mid-traffic
    dmem_resp = 1; dmem_rdata = 32'hBAD;
    step();
    dmem_resp = 0;
    sample_check();
    chk("unexp_set", unexp_resp, 1);
    advance();
    step();
    chk("unexp_sticky", unexp_resp, 1);
    m0_req = 1; dmem_gnt = 1;
    step(); step();
    rst = 0;
    #1;
    chk("rst_clears_unexp", unexp_resp, 0);
    chk("rst_blocks_req", dmem_req, 0);
    step();
    rst = 1;
    idle_inputs();
    step();
    dmem_resp = 1; dmem_rdata = 32'h77;
    sample_check();
    chk("stray_no_m0", m0_resp, 0);
    advance();
    dmem_resp = 0;
    sample_check();
    chk("stray_sets_unexp", unexp_resp, 1);
    advance();

    // Randomized traffic against the model
    rst = 0; step(); rst = 1;
    for (int i = 0; i < 400; i++) begin
      m0_req = $urandom_range(0, 1); m1_req = $urandom_range(0, 1);
      m0_cmd = $urandom_range(0, 1); m1_cmd = $urandom_range(0, 1);
      m0_width = 2'($urandom_range(0, 2)); m1_width = 2'($urandom_range(0, 2));
      m0_addr = $urandom; m1_addr = $urandom;
      m0_wdata = $urandom; m1_wdata = $urandom;
      dmem_gnt = ($urandom_range(0, 3) != 0);
      dmem_resp = ($urandom_range(0, 2) == 0);
      dmem_err = ($urandom_range(0, 4) == 0);
      dmem_rdata = $urandom;
      clear_pipeline = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter that shares the single data-memory port between the LSU (master 0) and a secondary requester such as a debug/DMA engine (master 1). Sits between the masters and the dmem bus. Grants one request per cycle with round-robin priority and tracks up to `DEPTH` outstanding requests in an in-order routing FIFO. Each in-order response is steered back to its issuing master; LSU responses are discarded after a pipeline clear.

## Interface
- `XLEN`, 32, data/address width
- `DEPTH`, 4, max outstanding requests (power of two, ≥2)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `m0_req`, `m1_req`  in  1  request valid per master
- `m0_cmd`, `m1_cmd`  in  1  1 = write, 0 = read
- `m0_width`, `m1_width`  in  2  access size (0 byte, 1 half, 2 word)
- `m0_addr`, `m1_addr`  in  XLEN  byte address
- `m0_wdata`, `m1_wdata`  in  XLEN  write data
- `m0_gnt`, `m1_gnt`  out  1  request accepted this cycle
- `m0_rdata`, `m1_rdata`  out  XLEN  response data; 0 when no response
- `m0_resp`, `m1_resp`  out  1  response valid
- `m0_err`, `m1_err`  out  1  response error; 0 when no response
- `dmem_req`, `dmem_cmd`, `dmem_width`, `dmem_addr`, `dmem_wdata`  out  1/1/2/XLEN/XLEN  downstream request
- `dmem_gnt`  in  1  downstream accepts request
- `dmem_rdata`  in  XLEN  downstream read data
- `dmem_resp`, `dmem_err`  in  1  downstream response, error
- `clear_pipeline`  in  1  flush: drop pending and in-flight master-0 traffic
- `unexp_resp`  out  1  sticky: response arrived with FIFO empty

## Operation
- Eligibility: `m0` needs `m0_req & ~clear_pipeline`; `m1` needs `m1_req`. FIFO space: `count < DEPTH`, or `count == DEPTH` with `dmem_resp` popping this cycle.
- Round-robin: a 1-bit `last` register holds the last-granted master; when both are eligible, the other master wins. A lone eligible master wins unconditionally.
- `dmem_req` = winner exists & space. Request fields mux from the winner; all zero when `dmem_req` = 0.
- `mX_gnt` = (winner == X) & `dmem_req` & `dmem_gnt`. On grant: push {owner, drop=0} and update `last`.
- Response: `dmem_resp` with FIFO non-empty pops the head.
  - drop = 0: assert the owner's `resp`/`rdata`/`err` combinationally.
  - drop = 1: the response is swallowed.
- `dmem_resp` with FIFO empty: set `unexp_resp`, which stays set until reset. Nothing is forwarded.
- `clear_pipeline`: set drop on every valid owner-0 entry, including an entry pushed in the same cycle (`m0` is blocked that cycle, so none is pushed). A head popping that same cycle is still forwarded. Owner-1 entries are untouched.
- Simultaneous push and pop: `count` unchanged and pointers both advance. Pointers wrap modulo `DEPTH`; `count` width is clog2(`DEPTH`+1).

## Timing
- Request path is fully combinational, zero latency: `mX_req` → `dmem_req` → `mX_gnt` in the same cycle.
- Response path is combinational from the FIFO head and `dmem_resp`.
- FIFO, `last`, drop bits and `unexp_resp` update on the rising edge.
- Reset values: FIFO empty, `count` = 0, `last` = 1 (master 0 has first priority), `unexp_resp` = 0. All outputs 0 during reset.
- Reset mid-operation discards all outstanding entries. Later stray responses set `unexp_resp`.
- Throughput: one grant per cycle. Full FIFO with no pop → `dmem_req` = 0.

## Structure
- Shared package/`define.v`: `XLEN`, width encodings, and the `cmd` encoding (shared with the LSU).
- One sub-module: `dmem_route_fifo`, which holds the owner and drop bits, the pointers, the count and a drop-all-owner-0 input.
- Arbitration and muxing live in the top level.

## Test plan
- Single read: `m0` reads 0x100, `dmem_gnt` = 1, response 0xDEADBEEF two cycles later → `m0_resp` = 1, `m0_rdata` = 0xDEADBEEF, `m1_resp` = 0.
- Contention: both masters request every cycle, `dmem_gnt` = 1 → grants alternate m0, m1, m0, m1 after reset; responses return to the matching owner in order.
- Backpressure/full: `DEPTH` = 4, four grants, no responses → fifth `dmem_req` = 0. A response in the next cycle lets a new grant occur in that same cycle.
- Flush: m0, m1, m0 outstanding, then `clear_pipeline` → only `m1_resp` pulses. Both m0 responses are dropped and `m0_req` is not granted in the flush cycle.
- Error routing: m1 write with `dmem_err` = 1 on the response → `m1_err` = 1, `m1_rdata` forwarded, `m0_err` = 0.
- Unexpected response/reset: `dmem_resp` with the FIFO empty → `unexp_resp` = 1 and stays 1. Asserting `rst` low mid-traffic clears it and `count` immediately.
